// File: rtl/clock_setter_if.sv
// clock_setter_if: request, status, segment readback and button lines between the setter and the alarm clock.
interface clock_setter_if;
    logic       start;
    logic [5:0] tgt_min;
    logic [4:0] tgt_hrs;
    logic [2:0] tgt_day;
    logic [4:0] tgt_date;
    logic [3:0] tgt_month;
    logic [6:0] M1disp, M0disp, H1disp, H0disp, D0disp;
    logic [6:0] Date1disp, Date0disp, Month1disp, Month0disp;
    logic       Timeset, Minadv, Hrsadv, Dayadv, Dateadv, Monthadv;
    logic       busy, done;
    logic [1:0] err;
    modport master (
        input  start, tgt_min, tgt_hrs, tgt_day, tgt_date, tgt_month,
        input  M1disp, M0disp, H1disp, H0disp, D0disp,
        input  Date1disp, Date0disp, Month1disp, Month0disp,
        output Timeset, Minadv, Hrsadv, Dayadv, Dateadv, Monthadv,
        output busy, done, err
    );
    modport slave (
        output start, tgt_min, tgt_hrs, tgt_day, tgt_date, tgt_month,
        output M1disp, M0disp, H1disp, H0disp, D0disp,
        output Date1disp, Date0disp, Month1disp, Month0disp,
        input  Timeset, Minadv, Hrsadv, Dayadv, Dateadv, Monthadv,
        input  busy, done, err
    );
endinterface

// File: rtl/clock_setter.sv
// clock_setter: steps the alarm clock's advance buttons until its decoded display matches a target.
// Define DATE_SET_EN to also set month and date (month first, since the date modulus depends on it).
module clock_setter #(
    parameter int NS         = 60,
    parameter int NH         = 24,
    parameter int STEP_LIMIT = 63
) (
    input logic clk,
    input logic rst,
    clock_setter_if.master bus
);
    localparam int CW = $clog2(STEP_LIMIT + 1);
    localparam logic [2:0] F_MON = 3'd0, F_DATE = 3'd1, F_HRS = 3'd2, F_MIN = 3'd3, F_DAY = 3'd4;
`ifdef DATE_SET_EN
    localparam logic [2:0] F_FIRST = F_MON;
`else
    localparam logic [2:0] F_FIRST = F_HRS;
`endif

    typedef enum logic [2:0] {S_IDLE, S_ARM, S_SETTLE, S_CMP, S_STEP, S_WAIT, S_REL, S_DONE} state_t;

    state_t        state_q, state_d;
    logic [2:0]    fld_q, fld_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    err_q, err_d;
    logic [5:0]    min_q, min_d;
    logic [4:0]    hrs_q, hrs_d;
    logic [2:0]    day_q, day_d;
    logic [7:0]    rb;
    logic [6:0]    tv;
    logic          bad;

    function automatic logic [4:0] seg_dec(input logic [6:0] s);
        case (s)
            7'h3F:   seg_dec = 5'h10;
            7'h06:   seg_dec = 5'h11;
            7'h5B:   seg_dec = 5'h12;
            7'h4F:   seg_dec = 5'h13;
            7'h66:   seg_dec = 5'h14;
            7'h6D:   seg_dec = 5'h15;
            7'h7D:   seg_dec = 5'h16;
            7'h07:   seg_dec = 5'h17;
            7'h7F:   seg_dec = 5'h18;
            7'h6F:   seg_dec = 5'h19;
            default: seg_dec = 5'h00;
        endcase
    endfunction

    // {valid, 10*tens + ones}
    function automatic logic [7:0] pair_dec(input logic [6:0] t, input logic [6:0] o);
        logic [4:0] a, b;
        a = seg_dec(t);
        b = seg_dec(o);
        pair_dec = {a[4] & b[4], 7'(a[3:0]) * 7'd10 + 7'(b[3:0])};
    endfunction

`ifdef DATE_SET_EN
    logic [4:0] date_q, date_d;
    logic [3:0] mon_q, mon_d;

    function automatic logic [4:0] dim(input logic [3:0] m);
        dim = m == 4'd2 ? 5'd28 : (m == 4'd4 || m == 4'd6 || m == 4'd9 || m == 4'd11) ? 5'd30 : 5'd31;
    endfunction

    assign bad = 32'(bus.tgt_min) >= NS || 32'(bus.tgt_hrs) >= NH || bus.tgt_day > 3'd6 ||
                 bus.tgt_month == 4'd0 || bus.tgt_month > 4'd12 ||
                 bus.tgt_date == 5'd0 || bus.tgt_date > dim(bus.tgt_month);
    assign rb = fld_q == F_MON  ? pair_dec(bus.Month1disp, bus.Month0disp) :
                fld_q == F_DATE ? pair_dec(bus.Date1disp, bus.Date0disp) :
                fld_q == F_HRS  ? pair_dec(bus.H1disp, bus.H0disp) :
                fld_q == F_MIN  ? pair_dec(bus.M1disp, bus.M0disp) :
                                  pair_dec(7'h3F, bus.D0disp);
    assign tv = fld_q == F_MON  ? 7'(mon_q) :
                fld_q == F_DATE ? 7'(date_q) :
                fld_q == F_HRS  ? 7'(hrs_q) :
                fld_q == F_MIN  ? 7'(min_q) : 7'(day_q);
`else
    assign bad = 32'(bus.tgt_min) >= NS || 32'(bus.tgt_hrs) >= NH || bus.tgt_day > 3'd6;
    assign rb = fld_q == F_HRS ? pair_dec(bus.H1disp, bus.H0disp) :
                fld_q == F_MIN ? pair_dec(bus.M1disp, bus.M0disp) :
                                 pair_dec(7'h3F, bus.D0disp);
    assign tv = fld_q == F_HRS ? 7'(hrs_q) : fld_q == F_MIN ? 7'(min_q) : 7'(day_q);
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            fld_q   <= F_FIRST;
            cnt_q   <= '0;
            err_q   <= 2'd0;
            min_q   <= '0;
            hrs_q   <= '0;
            day_q   <= '0;
`ifdef DATE_SET_EN
            date_q  <= '0;
            mon_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            fld_q   <= fld_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            min_q   <= min_d;
            hrs_q   <= hrs_d;
            day_q   <= day_d;
`ifdef DATE_SET_EN
            date_q  <= date_d;
            mon_q   <= mon_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        fld_d   = fld_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        min_d   = min_q;
        hrs_d   = hrs_q;
        day_d   = day_q;
`ifdef DATE_SET_EN
        date_d  = date_q;
        mon_d   = mon_q;
`endif
        case (state_q)
            S_IDLE: if (bus.start) begin
                min_d   = bus.tgt_min;
                hrs_d   = bus.tgt_hrs;
                day_d   = bus.tgt_day;
`ifdef DATE_SET_EN
                date_d  = bus.tgt_date;
                mon_d   = bus.tgt_month;
`endif
                err_d   = bad ? 2'd1 : 2'd0;
                state_d = bad ? S_DONE : S_ARM;
            end
            S_ARM:    state_d = S_SETTLE;
            S_SETTLE: begin
                fld_d   = F_FIRST;
                cnt_d   = '0;
                state_d = S_CMP;
            end
            S_CMP: begin
                if (!rb[7]) begin
                    err_d   = 2'd2;
                    state_d = S_REL;
                end else if (rb[6:0] == tv) begin
                    cnt_d   = '0;
                    fld_d   = fld_q + 3'd1;
                    state_d = fld_q == F_DAY ? S_REL : S_CMP;
                end else if (cnt_q == CW'(STEP_LIMIT)) begin
                    err_d   = 2'd3;
                    state_d = S_REL;
                end else begin
                    state_d = S_STEP;
                end
            end
            // the display reflects a strobe only after the following edge, hence the wait
            S_STEP: begin
                cnt_d   = cnt_q + CW'(1);
                state_d = S_WAIT;
            end
            S_WAIT:  state_d = S_CMP;
            S_REL:   state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        bus.Timeset = state_q inside {S_ARM, S_SETTLE, S_CMP, S_STEP, S_WAIT};
        bus.Minadv  = state_q == S_STEP && fld_q == F_MIN;
        bus.Hrsadv  = state_q == S_STEP && fld_q == F_HRS;
        bus.Dayadv  = state_q == S_STEP && fld_q == F_DAY;
`ifdef DATE_SET_EN
        bus.Dateadv  = state_q == S_STEP && fld_q == F_DATE;
        bus.Monthadv = state_q == S_STEP && fld_q == F_MON;
`else
        bus.Dateadv  = 1'b0;
        bus.Monthadv = 1'b0;
`endif
        bus.busy = !(state_q inside {S_IDLE, S_DONE});
        bus.done = state_q == S_DONE;
        bus.err  = err_q;
    end
endmodule

// File: tb/tb_clock_setter.sv
// tb_clock_setter: drives clock_setter against a behavioural alarm-clock model with a result scoreboard.
module tb_clock_setter;
`ifdef DATE_SET_EN
    localparam int NF = 5;
`else
    localparam int NF = 3;
`endif

    typedef struct {
        int err, nmin, nhrs, nday, nmon, ndate, lat;
        int fmin, fhrs, fday, fdate, fmon;
    } exp_t;

    logic clk = 0, rst = 0;
    clock_setter_if bus();
    clock_setter #(.NS(60), .NH(24), .STEP_LIMIT(63)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    int checks = 0, errors = 0;
    exp_t sb[$];

    int mmin = 0, mhrs = 0, mday = 0, mdate = 1, mmon = 1;
    int ld_min, ld_hrs, ld_day, ld_date, ld_mon;
    logic ld = 0, ign_min = 0, bad_m0 = 0;

    function automatic logic [6:0] seg7(input int d);
        case (d)
            0: seg7 = 7'h3F; 1: seg7 = 7'h06; 2: seg7 = 7'h5B; 3: seg7 = 7'h4F; 4: seg7 = 7'h66;
            5: seg7 = 7'h6D; 6: seg7 = 7'h7D; 7: seg7 = 7'h07; 8: seg7 = 7'h7F; 9: seg7 = 7'h6F;
            default: seg7 = 7'h00;
        endcase
    endfunction

    function automatic int mdays(input int m);
        mdays = m == 2 ? 28 : (m == 4 || m == 6 || m == 9 || m == 11) ? 30 : 31;
    endfunction

    always @(posedge clk) begin
        if (ld) begin
            mmin <= ld_min; mhrs <= ld_hrs; mday <= ld_day; mdate <= ld_date; mmon <= ld_mon;
        end else if (bus.Timeset) begin
            if (bus.Minadv && !ign_min) mmin <= mmin == 59 ? 0 : mmin + 1;
            if (bus.Hrsadv)   mhrs  <= mhrs == 23 ? 0 : mhrs + 1;
            if (bus.Dayadv)   mday  <= mday == 6 ? 0 : mday + 1;
            if (bus.Dateadv)  mdate <= mdate >= mdays(mmon) ? 1 : mdate + 1;
            if (bus.Monthadv) mmon  <= mmon == 12 ? 1 : mmon + 1;
        end
    end

    assign bus.M1disp     = seg7(mmin / 10);
    assign bus.M0disp     = bad_m0 ? 7'h00 : seg7(mmin % 10);
    assign bus.H1disp     = seg7(mhrs / 10);
    assign bus.H0disp     = seg7(mhrs % 10);
    assign bus.D0disp     = seg7(mday);
    assign bus.Date1disp  = seg7(mdate / 10);
    assign bus.Date0disp  = seg7(mdate % 10);
    assign bus.Month1disp = seg7(mmon / 10);
    assign bus.Month0disp = seg7(mmon % 10);

    int n_min = 0, n_hrs = 0, n_day = 0, n_date = 0, n_mon = 0, n_ts = 0, n_multi = 0, n_nots = 0;
    always @(negedge clk) begin
        automatic int a = int'(bus.Minadv) + int'(bus.Hrsadv) + int'(bus.Dayadv) + int'(bus.Dateadv) + int'(bus.Monthadv);
        n_min  = n_min + int'(bus.Minadv);
        n_hrs  = n_hrs + int'(bus.Hrsadv);
        n_day  = n_day + int'(bus.Dayadv);
        n_date = n_date + int'(bus.Dateadv);
        n_mon  = n_mon + int'(bus.Monthadv);
        n_ts   = n_ts + int'(bus.Timeset);
        if (a > 1) n_multi++;
        if (a > 0 && !bus.Timeset) n_nots++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic load(input int mi, input int h, input int d, input int dt, input int mo);
        ld_min = mi; ld_hrs = h; ld_day = d; ld_date = dt; ld_mon = mo;
        ld = 1;
        @(posedge clk); #1;
        ld = 0;
    endtask

    task automatic run_op(input string name, input int tm, input int th, input int td, input int tdt,
                          input int tmo, input int eerr, input int emin, input int ehrs, input int eday,
                          input int emon, input int edate, input int elat);
        exp_t e, g;
        int lat, s_min, s_hrs, s_day, s_date, s_mon, s_ts, bsy;
        logic got;
        e.err = eerr; e.nmin = emin; e.nhrs = ehrs; e.nday = eday; e.nmon = emon; e.ndate = edate;
        e.lat = eerr == 0 ? 4 + NF + 3 * (emin + ehrs + eday + emon + edate) : elat;
        e.fmin = tm; e.fhrs = th; e.fday = td; e.fdate = tdt; e.fmon = tmo;
        sb.push_back(e);
        s_min = n_min; s_hrs = n_hrs; s_day = n_day; s_date = n_date; s_mon = n_mon; s_ts = n_ts;
        bus.tgt_min = 6'(tm); bus.tgt_hrs = 5'(th); bus.tgt_day = 3'(td);
        bus.tgt_date = 5'(tdt); bus.tgt_month = 4'(tmo);
        bus.start = 1;
        lat = 0; got = 0; bsy = 0;
        while (!got && lat < 3000) begin
            @(posedge clk); #1;
            lat++;
            bus.start = 0;
            if (lat == 1) begin
                bsy = int'(bus.busy);
                bus.tgt_min = 6'($urandom); bus.tgt_hrs = 5'($urandom); bus.tgt_day = 3'($urandom);
                bus.tgt_date = 5'($urandom); bus.tgt_month = 4'($urandom);
            end
            if (lat == 3 && eerr != 1) bus.start = 1;
            if (bus.done) got = 1;
        end
        chk({name, "_done_seen"}, got, 1);
        g = sb.pop_front();
        chk({name, "_busy"}, bsy, g.err != 1);
        chk({name, "_err"}, bus.err, g.err);
        if (g.lat >= 0) chk({name, "_latency"}, lat, g.lat);
        chk({name, "_busy_at_done"}, bus.busy, 0);
        chk({name, "_timeset_at_done"}, bus.Timeset, 0);
        chk({name, "_timeset_seen"}, n_ts > s_ts, g.err != 1);
        chk({name, "_minadv"}, n_min - s_min, g.nmin);
        chk({name, "_hrsadv"}, n_hrs - s_hrs, g.nhrs);
        chk({name, "_dayadv"}, n_day - s_day, g.nday);
        chk({name, "_monthadv"}, n_mon - s_mon, g.nmon);
        chk({name, "_dateadv"}, n_date - s_date, g.ndate);
        if (g.err == 0) begin
            chk({name, "_final_min"}, mmin, g.fmin);
            chk({name, "_final_hrs"}, mhrs, g.fhrs);
            chk({name, "_final_day"}, mday, g.fday);
`ifdef DATE_SET_EN
            chk({name, "_final_date"}, mdate, g.fdate);
            chk({name, "_final_month"}, mmon, g.fmon);
`endif
        end
        @(posedge clk); #1;
        chk({name, "_done_one_cycle"}, bus.done, 0);
        chk({name, "_err_held"}, bus.err, g.err);
    endtask

    function automatic logic [11:0] outs();
        outs = {bus.Timeset, bus.Minadv, bus.Hrsadv, bus.Dayadv, bus.Dateadv, bus.Monthadv,
                bus.busy, bus.done, bus.err, 2'b00};
    endfunction

    initial begin
        int k;
        bus.start = 0; bus.tgt_min = 0; bus.tgt_hrs = 0; bus.tgt_day = 0; bus.tgt_date = 1; bus.tgt_month = 1;
        ld_min = 0; ld_hrs = 0; ld_day = 0; ld_date = 1; ld_mon = 1;
        #1;
        chk("reset_outputs_low", outs(), 0);
        repeat (3) @(posedge clk);
        #1 rst = 1;
        chk("idle_outputs_low", outs(), 0);
        load(0, 0, 0, 1, 1);

        run_op("zero",      0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, -1);
        load(58, 10, 0, 1, 1);
        run_op("wrap_min", 2, 11, 0, 1, 1, 0, 4, 1, 0, 0, 0, -1);
        run_op("day",       2, 11, 5, 1, 1, 0, 0, 0, 5, 0, 0, -1);
        load(0, 0, 0, 1, 1);
        run_op("max_time", 59, 23, 6, 1, 1, 0, 59, 23, 6, 0, 0, -1);
        run_op("bad_min",  60, 0, 0, 1, 1, 1, 0, 0, 0, 0, 0, 1);
        run_op("bad_hrs",   0, 24, 0, 1, 1, 1, 0, 0, 0, 0, 0, 1);
        run_op("bad_day",   0, 0, 7, 1, 1, 1, 0, 0, 0, 0, 0, 1);

        load(0, 0, 0, 1, 1);
        bad_m0 = 1;
        run_op("bad_seg",   0, 0, 0, 1, 1, 2, 0, 0, 0, 0, 0, -1);
        bad_m0 = 0;

        ign_min = 1;
        run_op("timeout",   5, 0, 0, 1, 1, 3, 63, 0, 0, 0, 0, -1);
        ign_min = 0;

        rst = 0; #1;
        chk("reset_clears_err", bus.err, 0);
        @(posedge clk); #1 rst = 1;

`ifdef DATE_SET_EN
        run_op("bad_feb30", 0, 0, 0, 30, 2, 1, 0, 0, 0, 0, 0, 1);
        run_op("bad_month", 0, 0, 0, 1, 13, 1, 0, 0, 0, 0, 0, 1);
        load(0, 0, 0, 31, 1);
        run_op("apr30",     0, 0, 0, 30, 4, 0, 0, 0, 0, 3, 30, -1);
        load(0, 0, 0, 1, 1);
`endif

        bus.tgt_min = 6'd30; bus.tgt_hrs = 0; bus.tgt_day = 0; bus.tgt_date = 1; bus.tgt_month = 1;
        bus.start = 1;
        @(posedge clk); #1;
        bus.start = 0;
        k = 0;
        while (!bus.Minadv && k < 400) begin
            @(posedge clk); #1;
            k++;
        end
        chk("mid_step_reached", bus.Minadv, 1);
        rst = 0; #1;
        chk("mid_step_reset_outputs", outs(), 0);
        @(posedge clk); #1 rst = 1;
        @(posedge clk); #1;
        chk("post_reset_idle", outs(), 0);

        chk("one_adv_per_cycle", n_multi, 0);
        chk("adv_only_with_timeset", n_nots, 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
